// File: rtl/hazard_ctrl.sv
// rtl/hazard_ctrl.sv - load-use stall, taken-branch squash and halt/drain/step sequencing for the 5-stage pipe
module hazard_ctrl #(
    parameter int DRAIN_CYCLES = 4
) (
    input  logic        clk_in,
    input  logic        n_rst_in,
    input  logic [31:0] IFID_ir_in,
    input  logic        IDEX_mem_read_in,
    input  logic [4:0]  IDEX_rt_in,
    input  logic        MEM_ctrl_pc_src_in,
    input  logic        halt_in,
    input  logic        step_in,
    output logic        pc_write_out,
    output logic        IFID_write_out,
    output logic        IFID_flush_out,
    output logic        IDEX_flush_out,
    output logic        EXMEM_flush_out,
    output logic        halted_out,
    output logic [15:0] stall_cnt_out,
    output logic [15:0] flush_cnt_out
);

    typedef enum logic [1:0] {RUN, DRAIN, HALTED, STEP} state_t;

    localparam logic [3:0] DRAIN_LOAD = 4'(DRAIN_CYCLES);

    state_t     state, next_state;
    logic [3:0] drain_cnt, next_drain_cnt;
    logic [5:0] opcode;
    logic       rt_is_source;
    logic       lu, br, stall_inc;
    logic       pc_w, ifid_w, ifid_f, idex_f, exmem_f;

    assign opcode       = IFID_ir_in[31:26];
    // Only R-type, beq, bne and sw actually read the rt field as a source.
    assign rt_is_source = (opcode == 6'h00) || (opcode == 6'h04) ||
                          (opcode == 6'h05) || (opcode == 6'h2B);
    assign lu = IDEX_mem_read_in && (IDEX_rt_in != 5'd0) &&
                ((IDEX_rt_in == IFID_ir_in[25:21]) ||
                 ((IDEX_rt_in == IFID_ir_in[20:16]) && rt_is_source));
    assign br = MEM_ctrl_pc_src_in;
    assign stall_inc = lu && !br && ((state == RUN) || (state == STEP));

    always_comb begin
        next_state     = state;
        next_drain_cnt = drain_cnt;
        pc_w           = 1'b0;
        ifid_w         = 1'b0;
        ifid_f         = 1'b0;
        idex_f         = 1'b1;
        exmem_f        = 1'b0;
        case (state)
            RUN, STEP: begin
                if (!lu) begin
                    pc_w   = 1'b1;
                    ifid_w = 1'b1;
                    idex_f = 1'b0;
                end
                if (state == RUN) begin
                    if (halt_in) begin
                        next_state     = DRAIN;
                        next_drain_cnt = DRAIN_LOAD;
                    end
                end else if (!lu || br) begin
                    next_state     = DRAIN;
                    next_drain_cnt = DRAIN_LOAD;
                end
            end
            DRAIN: begin
                if (!halt_in) begin
                    next_state = RUN;
                end else if (drain_cnt == 4'd0) begin
                    next_state = HALTED;
                end else begin
                    next_drain_cnt = drain_cnt - 4'd1;
                end
            end
            HALTED: begin
                if (!halt_in) begin
                    next_state = RUN;
                end else if (step_in) begin
                    next_state = STEP;
                end
            end
            default: next_state = RUN;
        endcase
        if (br) begin
            pc_w    = 1'b1;
            ifid_w  = 1'b1;
            ifid_f  = 1'b1;
            idex_f  = 1'b1;
            exmem_f = 1'b1;
        end
    end

    // Strobes are held low for the whole time reset is asserted.
    assign pc_write_out    = n_rst_in & pc_w;
    assign IFID_write_out  = n_rst_in & ifid_w;
    assign IFID_flush_out  = n_rst_in & ifid_f;
    assign IDEX_flush_out  = n_rst_in & idex_f;
    assign EXMEM_flush_out = n_rst_in & exmem_f;

    always_ff @(posedge clk_in or negedge n_rst_in) begin
        if (!n_rst_in) begin
            state         <= RUN;
            drain_cnt     <= 4'd0;
            halted_out    <= 1'b0;
            stall_cnt_out <= 16'd0;
            flush_cnt_out <= 16'd0;
        end else begin
            state      <= next_state;
            drain_cnt  <= next_drain_cnt;
            halted_out <= (next_state == HALTED);
            if (stall_inc && (stall_cnt_out != 16'hFFFF)) begin
                stall_cnt_out <= stall_cnt_out + 16'd1;
            end
            if (br && (flush_cnt_out != 16'hFFFF)) begin
                flush_cnt_out <= flush_cnt_out + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb/tb_hazard_ctrl.sv - vector table, directed halt/step/reset sequences and random run against a reference model
module tb_hazard_ctrl;

    localparam int D = 4;

    logic        clk_in = 1'b0;
    logic        n_rst_in;
    logic [31:0] IFID_ir_in;
    logic        IDEX_mem_read_in;
    logic [4:0]  IDEX_rt_in;
    logic        MEM_ctrl_pc_src_in;
    logic        halt_in;
    logic        step_in;
    logic        pc_write_out, IFID_write_out, IFID_flush_out, IDEX_flush_out, EXMEM_flush_out;
    logic        halted_out;
    logic [15:0] stall_cnt_out, flush_cnt_out;

    hazard_ctrl #(.DRAIN_CYCLES(D)) dut (
        .clk_in(clk_in), .n_rst_in(n_rst_in), .IFID_ir_in(IFID_ir_in),
        .IDEX_mem_read_in(IDEX_mem_read_in), .IDEX_rt_in(IDEX_rt_in),
        .MEM_ctrl_pc_src_in(MEM_ctrl_pc_src_in), .halt_in(halt_in), .step_in(step_in),
        .pc_write_out(pc_write_out), .IFID_write_out(IFID_write_out),
        .IFID_flush_out(IFID_flush_out), .IDEX_flush_out(IDEX_flush_out),
        .EXMEM_flush_out(EXMEM_flush_out), .halted_out(halted_out),
        .stall_cnt_out(stall_cnt_out), .flush_cnt_out(flush_cnt_out)
    );

    always #5 clk_in = ~clk_in;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model: mode 0 running, 1 draining, 2 halted, 3 single-stepping.
    int m_mode = 0;
    int m_edges_left = 0;
    int m_stall = 0;
    int m_flush = 0;

    typedef struct {
        logic        mr;
        logic [4:0]  rt;
        logic [31:0] ir;
        logic        br;
        logic [4:0]  exp;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit model_lu(input logic mr, input logic [4:0] rt, input logic [31:0] ir);
        int op, rs_f, rt_f;
        op   = int'(ir >> 26);
        rs_f = int'((ir >> 21) & 32'h1F);
        rt_f = int'((ir >> 16) & 32'h1F);
        if (!mr || rt == 0) return 0;
        if (int'(rt) == rs_f) return 1;
        return (int'(rt) == rt_f) && (op == 0 || op == 4 || op == 5 || op == 'h2B);
    endfunction

    task automatic cycle(input logic mr, input logic [4:0] rt, input logic [31:0] ir,
                         input logic br, input logic hlt, input logic stp);
        bit lu;
        logic [4:0] e;
        IDEX_mem_read_in   = mr;
        IDEX_rt_in         = rt;
        IFID_ir_in         = ir;
        MEM_ctrl_pc_src_in = br;
        halt_in            = hlt;
        step_in            = stp;
        lu = model_lu(mr, rt, ir);
        if (br) e = 5'b11111;
        else if ((m_mode == 0 || m_mode == 3) && !lu) e = 5'b11000;
        else e = 5'b00010;
        #3;
        chk("pc_write", pc_write_out, e[4]);
        chk("ifid_write", IFID_write_out, e[3]);
        chk("ifid_flush", IFID_flush_out, e[2]);
        chk("idex_flush", IDEX_flush_out, e[1]);
        chk("exmem_flush", EXMEM_flush_out, e[0]);
        if (br) m_flush = (m_flush < 65535) ? m_flush + 1 : 65535;
        if (!br && lu && (m_mode == 0 || m_mode == 3)) m_stall = (m_stall < 65535) ? m_stall + 1 : 65535;
        case (m_mode)
            0: if (hlt) begin m_mode = 1; m_edges_left = D + 1; end
            1: if (!hlt) m_mode = 0;
               else begin
                   m_edges_left--;
                   if (m_edges_left == 0) m_mode = 2;
               end
            2: if (!hlt) m_mode = 0; else if (stp) m_mode = 3;
            default: if (br || !lu) begin m_mode = 1; m_edges_left = D + 1; end
        endcase
        @(posedge clk_in);
        #1;
        chk("halted", halted_out, (m_mode == 2));
        chk("stall_cnt", stall_cnt_out, m_stall);
        chk("flush_cnt", flush_cnt_out, m_flush);
    endtask

    function automatic logic [31:0] rtype(input int rs, input int rt, input int rd);
        return {6'h00, 5'(rs), 5'(rt), 5'(rd), 5'd0, 6'h20};
    endfunction

    function automatic logic [31:0] itype(input logic [5:0] op, input int rs, input int rt);
        return {op, 5'(rs), 5'(rt), 16'd0};
    endfunction

    logic [31:0] add_use;
    vec_t        vecs[10];
    int          k;

    initial begin
        n_rst_in = 1'b0;
        IFID_ir_in = '0; IDEX_mem_read_in = 0; IDEX_rt_in = '0;
        MEM_ctrl_pc_src_in = 0; halt_in = 0; step_in = 0;
        add_use = rtype(2, 4, 3);
        vecs[0] = '{1'b1, 5'd2, add_use,                  1'b0, 5'b00010};
        vecs[1] = '{1'b1, 5'd0, rtype(0, 0, 3),           1'b0, 5'b11000};
        vecs[2] = '{1'b1, 5'd5, itype(6'h23, 2, 5),       1'b0, 5'b11000};
        vecs[3] = '{1'b1, 5'd5, itype(6'h2B, 2, 5),       1'b0, 5'b00010};
        vecs[4] = '{1'b1, 5'd7, itype(6'h04, 1, 7),       1'b0, 5'b00010};
        vecs[5] = '{1'b0, 5'd2, add_use,                  1'b0, 5'b11000};
        vecs[6] = '{1'b1, 5'd2, add_use,                  1'b1, 5'b11111};
        vecs[7] = '{1'b0, 5'd0, rtype(1, 1, 1),           1'b1, 5'b11111};
        vecs[8] = '{1'b1, 5'd9, itype(6'h08, 3, 9),       1'b0, 5'b11000};
        vecs[9] = '{1'b1, 5'd9, rtype(1, 9, 2),           1'b0, 5'b00010};

        #2;
        chk("rst_pc_write", pc_write_out, 0);
        chk("rst_ifid_write", IFID_write_out, 0);
        chk("rst_flushes", {IFID_flush_out, IDEX_flush_out, EXMEM_flush_out}, 0);
        chk("rst_halted", halted_out, 0);
        chk("rst_counters", {stall_cnt_out, flush_cnt_out}, 0);
        #10 n_rst_in = 1'b1;
        @(posedge clk_in);
        #1;

        foreach (vecs[i]) begin
            IDEX_mem_read_in   = vecs[i].mr;
            IDEX_rt_in         = vecs[i].rt;
            IFID_ir_in         = vecs[i].ir;
            MEM_ctrl_pc_src_in = vecs[i].br;
            #2;
            chk($sformatf("vec%0d_outputs", i),
                {pc_write_out, IFID_write_out, IFID_flush_out, IDEX_flush_out, EXMEM_flush_out},
                vecs[i].exp);
            cycle(vecs[i].mr, vecs[i].rt, vecs[i].ir, vecs[i].br, 1'b0, 1'b0);
        end
        chk("table_stalls", stall_cnt_out, 4);
        chk("table_flushes", flush_cnt_out, 2);

        // Halt: halted_out must rise exactly DRAIN_CYCLES+1 edges after the sampling edge.
        cycle(1'b0, 5'd0, 32'd0, 1'b0, 1'b1, 1'b0);
        k = 0;
        while (!halted_out && k < 20) begin
            cycle(1'b0, 5'd0, 32'd0, 1'b0, 1'b1, 1'b0);
            k++;
        end
        chk("drain_len", k, D + 1);
        cycle(1'b0, 5'd0, 32'd0, 1'b0, 1'b0, 1'b0);
        chk("unhalt", halted_out, 0);

        // Single step from HALTED, first clean then blocked by a load-use hazard.
        for (int s = 0; s < 2; s++) begin
            repeat (D + 3) cycle(1'b0, 5'd0, 32'd0, 1'b0, 1'b1, 1'b0);
            chk("step_pre_halted", halted_out, 1);
            cycle(1'b0, 5'd0, 32'd0, 1'b0, 1'b1, 1'b1);
            if (s == 1) begin
                cycle(1'b1, 5'd2, add_use, 1'b0, 1'b1, 1'b0);
                cycle(1'b1, 5'd2, add_use, 1'b0, 1'b1, 1'b0);
            end
            cycle(1'b0, 5'd0, 32'd0, 1'b0, 1'b1, 1'b0);
            k = 0;
            while (!halted_out && k < 20) begin
                cycle(1'b0, 5'd0, 32'd0, 1'b0, 1'b1, 1'b0);
                k++;
            end
            chk("step_redrain_len", k, D + 1);
        end

        // Async reset in the middle of DRAIN.
        cycle(1'b0, 5'd0, 32'd0, 1'b0, 1'b0, 1'b0);
        cycle(1'b0, 5'd0, 32'd0, 1'b0, 1'b1, 1'b0);
        cycle(1'b0, 5'd0, 32'd0, 1'b0, 1'b1, 1'b0);
        n_rst_in = 1'b0;
        #1;
        chk("midrst_outputs",
            {pc_write_out, IFID_write_out, IFID_flush_out, IDEX_flush_out, EXMEM_flush_out, halted_out}, 0);
        chk("midrst_counters", {stall_cnt_out, flush_cnt_out}, 0);
        n_rst_in = 1'b1;
        m_mode = 0; m_stall = 0; m_flush = 0;
        cycle(1'b0, 5'd0, 32'd0, 1'b0, 1'b0, 1'b0);

        // Randomized run against the model.
        begin
            logic        hlt;
            logic [5:0]  ops[6];
            ops = '{6'h00, 6'h04, 6'h05, 6'h2B, 6'h23, 6'h08};
            hlt = 1'b0;
            for (int c = 0; c < 3000; c++) begin
                if ($urandom_range(29) == 0) hlt = ~hlt;
                cycle(1'($urandom_range(1)), 5'($urandom_range(3)),
                      {ops[$urandom_range(5)], 5'($urandom_range(3)), 5'($urandom_range(3)), 16'($urandom)},
                      ($urandom_range(9) == 0), hlt, ($urandom_range(5) == 0));
            end
        end

        // Stall counter saturation.
        cycle(1'b0, 5'd0, 32'd0, 1'b0, 1'b0, 1'b0);
        cycle(1'b0, 5'd0, 32'd0, 1'b0, 1'b0, 1'b0);
        IDEX_mem_read_in = 1'b1; IDEX_rt_in = 5'd2; IFID_ir_in = add_use;
        MEM_ctrl_pc_src_in = 1'b0; halt_in = 1'b0; step_in = 1'b0;
        repeat (70000) @(posedge clk_in);
        #1;
        m_stall = (m_stall + 70000 > 65535) ? 65535 : m_stall + 70000;
        chk("stall_saturated", stall_cnt_out, 16'hFFFF);
        cycle(1'b1, 5'd2, add_use, 1'b0, 1'b0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
